// File: rtl/branch_resolve_ctrl.sv
// branch_resolve_ctrl
// Resolves one conditional branch per handshake for the execute stage.
// It compares the computed direction with the fetch-time prediction and
// trains a 2-bit saturating branch history table (BHT). On a misprediction
// it holds a redirect request toward IF until IF accepts it.
// Optional build macro BRANCH_RESOLVE_PERF_EN adds two 32-bit counters:
// one counts resolved branches and one counts mispredictions.

module branch_resolve_ctrl #(
  parameter int BHT_IDX_W = 6,
  parameter int XLEN      = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [XLEN-1:0] in_pc_i,
  input  logic [XLEN-1:0] in_reg1_i,
  input  logic [XLEN-1:0] in_reg2_i,
  input  logic [2:0]      in_type_i,
  input  logic [XLEN-1:0] in_imm_i,
  input  logic            in_pred_taken_i,
  input  logic            flush_i,
  output logic            res_valid_o,
  output logic            res_taken_o,
  output logic            res_mispred_o,
  output logic            redir_valid_o,
  input  logic            redir_ready_i,
  output logic [XLEN-1:0] redir_pc_o,
  input  logic [XLEN-1:0] lkp_pc_i,
  output logic            lkp_taken_o
`ifdef BRANCH_RESOLVE_PERF_EN
  ,
  output logic [31:0]     perf_branches_o,
  output logic [31:0]     perf_mispreds_o
`endif
);

  localparam int BHT_N = 1 << BHT_IDX_W;

  // Branch type encoding
  localparam logic [2:0] T_EQ  = 3'b001;
  localparam logic [2:0] T_GE  = 3'b010;
  localparam logic [2:0] T_GEU = 3'b011;
  localparam logic [2:0] T_LT  = 3'b100;
  localparam logic [2:0] T_LTU = 3'b101;
  localparam logic [2:0] T_NE  = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EVAL  = 2'd1,
    S_REDIR = 2'd2
  } state_e;

  state_e          state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] reg1_q;
  logic [XLEN-1:0] reg2_q;
  logic [2:0]      type_q;
  logic [XLEN-1:0] imm_q;
  logic            pred_q;
  logic [XLEN-1:0] redir_pc_q;

  logic            taken_d;
  logic            type_ok_d;
  logic            mispred_d;
  logic [XLEN-1:0] target_d;
  logic            eval_fire_d;
  logic            bht_upd_d;
  logic [BHT_IDX_W-1:0] upd_idx_d;
  logic [BHT_IDX_W-1:0] lkp_idx_d;

  logic [1:0] bht_q [BHT_N];
  logic [1:0] bht_d [BHT_N];

  // The upper and lower lookup PC bits do not select a BHT entry.
  logic unused_lkp_bits;
  assign unused_lkp_bits = ^{lkp_pc_i[XLEN-1:BHT_IDX_W+2], lkp_pc_i[1:0]};

  // Compare the captured operands and derive the direction, target and misprediction flag.
  always_comb begin
    taken_d   = 1'b0;
    type_ok_d = 1'b1;
    case (type_q)
      T_EQ:    taken_d = (reg1_q == reg2_q);
      T_GE:    taken_d = !($signed(reg1_q) < $signed(reg2_q));
      T_GEU:   taken_d = !(reg1_q < reg2_q);
      T_LT:    taken_d = ($signed(reg1_q) < $signed(reg2_q));
      T_LTU:   taken_d = (reg1_q < reg2_q);
      T_NE:    taken_d = (reg1_q != reg2_q);
      default: type_ok_d = 1'b0;
    endcase
    // Both the taken and the fall-through target wrap modulo 2^XLEN.
    target_d    = taken_d ? (pc_q + imm_q) : (pc_q + XLEN'(4));
    mispred_d   = taken_d ^ pred_q;
    // A flush in the evaluation cycle cancels every visible effect.
    eval_fire_d = (state_q == S_EVAL) && !flush_i;
    bht_upd_d   = eval_fire_d && type_ok_d;
    upd_idx_d   = pc_q[BHT_IDX_W+1:2];
    lkp_idx_d   = lkp_pc_i[BHT_IDX_W+1:2];
  end

  assign in_ready_o    = rst_n && (state_q == S_IDLE);
  assign res_valid_o   = eval_fire_d;
  assign res_taken_o   = eval_fire_d && taken_d;
  assign res_mispred_o = eval_fire_d && mispred_d;
  assign redir_valid_o = (state_q == S_REDIR) && !flush_i;
  assign redir_pc_o    = redir_pc_q;
  // Reads the current array contents, so a same-cycle update is not yet visible.
  assign lkp_taken_o   = bht_q[lkp_idx_d][1];

  // Control FSM: captures the request, evaluates it for one cycle, and holds the redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      reg1_q     <= '0;
      reg2_q     <= '0;
      type_q     <= '0;
      imm_q      <= '0;
      pred_q     <= 1'b0;
      redir_pc_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // A flush here refers to older work; it does not block a new branch.
          if (in_valid_i) begin
            pc_q    <= in_pc_i;
            reg1_q  <= in_reg1_i;
            reg2_q  <= in_reg2_i;
            type_q  <= in_type_i;
            imm_q   <= in_imm_i;
            pred_q  <= in_pred_taken_i;
            state_q <= S_EVAL;
          end
        end
        S_EVAL: begin
          if (flush_i) begin
            state_q <= S_IDLE;
          end else if (mispred_d) begin
            redir_pc_q <= target_d;
            state_q    <= S_REDIR;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_REDIR: begin
          if (flush_i || redir_ready_i) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Saturating next-state for each BHT entry; only the addressed entry moves.
  generate
    for (genvar gi = 0; gi < BHT_N; gi++) begin : g_bht_next
      always_comb begin
        bht_d[gi] = bht_q[gi];
        if (bht_upd_d && (upd_idx_d == BHT_IDX_W'(gi))) begin
          if (taken_d) begin
            bht_d[gi] = (bht_q[gi] == 2'b11) ? 2'b11 : bht_q[gi] + 2'b01;
          end else begin
            bht_d[gi] = (bht_q[gi] == 2'b00) ? 2'b00 : bht_q[gi] - 2'b01;
          end
        end
      end
    end
  endgenerate

  // BHT storage: every entry starts weakly not-taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_N; i++) begin
        bht_q[i] <= 2'b01;
      end
    end else begin
      for (int i = 0; i < BHT_N; i++) begin
        bht_q[i] <= bht_d[i];
      end
    end
  end

`ifdef BRANCH_RESOLVE_PERF_EN
  logic [31:0] perf_branches_q;
  logic [31:0] perf_mispreds_q;

  // Count resolved branches and mispredictions with valid types; both counters wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_branches_q <= '0;
      perf_mispreds_q <= '0;
    end else if (bht_upd_d) begin
      perf_branches_q <= perf_branches_q + 32'd1;
      if (mispred_d) begin
        perf_mispreds_q <= perf_mispreds_q + 32'd1;
      end
    end
  end

  assign perf_branches_o = perf_branches_q;
  assign perf_mispreds_o = perf_mispreds_q;
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// tb_branch_resolve_ctrl
// Directed vectors with hand-computed expectations. Expected responses are
// queued at issue time. A negedge monitor pops them when the DUT presents
// a result or a redirect handshake.
module tb_branch_resolve_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_pc = '0;
  logic [63:0] in_reg1 = '0;
  logic [63:0] in_reg2 = '0;
  logic [2:0]  in_type = '0;
  logic [63:0] in_imm = '0;
  logic        in_pred_taken = 1'b0;
  logic        flush = 1'b0;
  logic        res_valid;
  logic        res_taken;
  logic        res_mispred;
  logic        redir_valid;
  logic        redir_ready = 1'b1;
  logic [63:0] redir_pc;
  logic [63:0] lkp_pc = '0;
  logic        lkp_taken;
`ifdef BRANCH_RESOLVE_PERF_EN
  logic [31:0] perf_branches;
  logic [31:0] perf_mispreds;
`endif

  always #5 clk = ~clk;

  branch_resolve_ctrl #(.BHT_IDX_W(6), .XLEN(64)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready),
    .in_pc_i        (in_pc),
    .in_reg1_i      (in_reg1),
    .in_reg2_i      (in_reg2),
    .in_type_i      (in_type),
    .in_imm_i       (in_imm),
    .in_pred_taken_i(in_pred_taken),
    .flush_i        (flush),
    .res_valid_o    (res_valid),
    .res_taken_o    (res_taken),
    .res_mispred_o  (res_mispred),
    .redir_valid_o  (redir_valid),
    .redir_ready_i  (redir_ready),
    .redir_pc_o     (redir_pc),
    .lkp_pc_i       (lkp_pc),
    .lkp_taken_o    (lkp_taken)
`ifdef BRANCH_RESOLVE_PERF_EN
    ,
    .perf_branches_o(perf_branches),
    .perf_mispreds_o(perf_mispreds)
`endif
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic t;
    logic m;
  } res_t;

  res_t        res_q[$];
  logic [63:0] redir_q[$];
  res_t        mon_res;
  logic [63:0] mon_pc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compares every presented result and redirect handshake with the queued expectations.
  always @(negedge clk) begin
    if (rst_n) begin
      if (res_valid) begin
        if (res_q.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL unexpected_res: got res_valid=1 expected no result");
        end else begin
          mon_res = res_q.pop_front();
          chk("res_taken", {63'd0, res_taken}, {63'd0, mon_res.t});
          chk("res_mispred", {63'd0, res_mispred}, {63'd0, mon_res.m});
          $display("[TB] result taken=%0d mispred=%0d", res_taken, res_mispred);
        end
      end
      if (redir_valid && redir_ready) begin
        if (redir_q.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL unexpected_redir: got redirect 0x%0h expected none", redir_pc);
        end else begin
          mon_pc = redir_q.pop_front();
          chk("redir_pc", redir_pc, mon_pc);
          $display("[TB] redirect pc=0x%0h", redir_pc);
        end
      end
    end
  end

  task automatic wait_ready(input string name);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("[TB] FAIL %s: got in_ready=0 expected 1 within 50 cycles", name);
    end
  endtask

  // Issues one branch and queues its hand-computed expected response; returns during the EVAL cycle.
  task automatic send(input logic [63:0] pc, input logic [63:0] r1, input logic [63:0] r2,
                      input logic [2:0] ty, input logic [63:0] imm, input logic pred,
                      input logic exp_t, input logic exp_m, input logic [63:0] exp_rpc,
                      input logic expect_res);
    res_t e;
    wait_ready("accept_timeout");
    if (expect_res) begin
      e.t = exp_t;
      e.m = exp_m;
      res_q.push_back(e);
      if (exp_m) redir_q.push_back(exp_rpc);
    end
    in_pc = pc;
    in_reg1 = r1;
    in_reg2 = r2;
    in_type = ty;
    in_imm = imm;
    in_pred_taken = pred;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic chk_lkp(input string name, input logic [63:0] pc, input logic exp);
    lkp_pc = pc;
    #1;
    chk(name, {63'd0, lkp_taken}, {63'd0, exp});
  endtask

  bit dirs[11] = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 1, 1};
  bit lkps[11] = '{1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 1};

  initial begin
    #2;
    // Reset state
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_res_valid", {63'd0, res_valid}, 64'd0);
    chk("rst_redir_valid", {63'd0, redir_valid}, 64'd0);
    chk("rst_redir_pc", redir_pc, 64'd0);
    chk_lkp("rst_lkp", 64'h8000_0000, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("idle_in_ready", {63'd0, in_ready}, 64'd1);

    // BEQ taken, predicted not-taken: result at N+1 and redirect at N+2.
    send(64'h8000_0000, 64'd5, 64'd5, 3'b001, 64'h10, 1'b0, 1'b1, 1'b1, 64'h8000_0010, 1'b1);
    chk("beq_res_at_n1", {63'd0, res_valid}, 64'd1);
    @(posedge clk);
    #1;
    chk("beq_redir_valid_n2", {63'd0, redir_valid}, 64'd1);
    chk("beq_redir_pc_n2", redir_pc, 64'h8000_0010);
    wait_ready("beq_idle");
    chk_lkp("beq_bht_idx0", 64'h8000_0000, 1'b1);

    // BLT signed taken, correctly predicted: no redirect and ready again at N+2.
    send(64'h2004, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'b100, 64'h20, 1'b1, 1'b1, 1'b0, 64'd0, 1'b1);
    @(posedge clk);
    #1;
    chk("blt_no_redir", {63'd0, redir_valid}, 64'd0);
    chk("blt_ready_n2", {63'd0, in_ready}, 64'd1);
    chk_lkp("blt_bht", 64'h2004, 1'b1);

    // BLTU unsigned not-taken with the same operands; the redirect is held for 5 cycles.
    redir_ready = 1'b0;
    send(64'h2004, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'b101, 64'h20, 1'b1, 1'b0, 1'b1, 64'h2008, 1'b1);
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("hold_redir_valid", {63'd0, redir_valid}, 64'd1);
      chk("hold_redir_pc", redir_pc, 64'h2008);
      chk("hold_in_ready", {63'd0, in_ready}, 64'd0);
      @(posedge clk);
      #1;
    end
    redir_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("release_in_ready", {63'd0, in_ready}, 64'd1);
    chk("release_redir_valid", {63'd0, redir_valid}, 64'd0);
    chk_lkp("bltu_bht", 64'h2004, 1'b0);

    // Saturation: a BNE at one PC, with direction and expected lookup from the tables.
    for (int i = 0; i < 11; i++) begin
      if (dirs[i])
        send(64'h1040, 64'd1, 64'd2, 3'b110, 64'h8, 1'b1, 1'b1, 1'b0, 64'd0, 1'b1);
      else
        send(64'h1040, 64'd3, 64'd3, 3'b110, 64'h8, 1'b0, 1'b0, 1'b0, 64'd0, 1'b1);
      wait_ready("sat_idle");
      chk_lkp($sformatf("sat_lkp_%0d", i), 64'h1040, lkps[i]);
    end

    // Flush in EVAL of a mispredicted branch: no result, no redirect, BHT entry untouched.
    send(64'h3008, 64'd7, 64'd7, 3'b001, 64'h100, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0);
    flush = 1'b1;
    #1;
    chk("flush_res_valid", {63'd0, res_valid}, 64'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_in_ready", {63'd0, in_ready}, 64'd1);
    chk("flush_redir_valid", {63'd0, redir_valid}, 64'd0);
    chk_lkp("flush_bht", 64'h3008, 1'b0);
    send(64'h3008, 64'd1, 64'd9, 3'b110, 64'h40, 1'b1, 1'b1, 1'b0, 64'd0, 1'b1);
    wait_ready("post_flush_idle");
    chk_lkp("post_flush_bht", 64'h3008, 1'b1);

    // Type 000 resolves as not-taken; a taken prediction still redirects to pc+4.
    send(64'h3010, 64'd4, 64'd4, 3'b000, 64'h40, 1'b1, 1'b0, 1'b1, 64'h3014, 1'b1);
    wait_ready("type0_idle");

    // Asynchronous reset during EVAL: outputs clear at once and the BHT returns to its reset value.
    send(64'h8000_0000, 64'd5, 64'd5, 3'b001, 64'h10, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_res_valid", {63'd0, res_valid}, 64'd0);
    chk("arst_redir_valid", {63'd0, redir_valid}, 64'd0);
    chk("arst_in_ready", {63'd0, in_ready}, 64'd0);
    chk_lkp("arst_bht_idx0", 64'h8000_0000, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // BGE not taken at the top of the address space: the fall-through target wraps to 0.
    send(64'hFFFF_FFFF_FFFF_FFFC, 64'd1, 64'd2, 3'b010, 64'h40, 1'b1, 1'b0, 1'b1, 64'h0, 1'b1);
    wait_ready("wrap_idle");
`ifdef BRANCH_RESOLVE_PERF_EN
    chk("perf_branches", {32'd0, perf_branches}, 64'd1);
    chk("perf_mispreds", {32'd0, perf_mispreds}, 64'd1);
`endif

    repeat (2) @(posedge clk);
    #1;
    chk("res_queue_drained", 64'(res_q.size()), 64'd0);
    chk("redir_queue_drained", 64'(redir_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/branch_resolve_ctrl.md
Name: branch_resolve_ctrl

Overview:
- Sequences branch resolution for the NPC execute stage.
- Accepts one conditional branch per handshake and evaluates the condition with its internal comparator, using the team's 3-bit branch Type encoding.
- Compares the outcome against the fetch-time prediction, trains a 2-bit-counter branch history table (BHT), and holds a redirect request to IF until it is accepted.
- Sits between ID/EX and the fetch redirect path; the BHT lookup port serves IF.

Parameters:
BHT_IDX_W, 6, log2 of BHT entry count; index = pc[BHT_IDX_W+1:2]
XLEN, 64, operand/PC width

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  branch request valid from EX
in_ready  output  1  controller can accept a request
in_pc  input  XLEN  branch instruction PC
in_reg1  input  XLEN  rs1 value
in_reg2  input  XLEN  rs2 value
in_type  input  3  001 EQ, 010 GE, 011 GEU, 100 LT, 101 LTU, 110 NE, others none
in_imm  input  XLEN  sign-extended branch offset
in_pred_taken  input  1  prediction made at fetch
flush  input  1  synchronous kill from older trap/redirect
res_valid  output  1  one-cycle pulse: resolution result valid
res_taken  output  1  resolved direction
res_mispred  output  1  resolved direction != prediction
redir_valid  output  1  redirect request to IF
redir_ready  input  1  IF accepts redirect
redir_pc  output  XLEN  corrected fetch PC
lkp_pc  input  XLEN  IF lookup PC
lkp_taken  output  1  prediction = BHT[lkp_pc idx][1]

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values:
  - State IDLE.
  - res_valid, res_taken, res_mispred, redir_valid = 0; redir_pc = 0.
  - All BHT entries = 2'b01 (weakly not-taken).
  - Captured operand registers = 0.
- in_ready = (state==IDLE). It is combinational from state only; 0 while rst_n low.
- IDLE:
  - On in_valid && in_ready, register pc, reg1, reg2, type, imm, pred_taken, then go to EVAL.
  - flush in IDLE has no effect and does not block acceptance.
- EVAL (exactly one cycle):
  - taken from the registered operands. Signed compare for GE/LT; unsigned for GEU/LTU; EQ/NE bitwise.
  - Types 000 and 111: taken=0, no BHT update.
  - target = taken ? pc+imm : pc+4, modulo 2^XLEN (wrap, no overflow flag).
  - mispred = taken ^ pred_taken.
  - res_valid pulses 1 this cycle, with res_taken and res_mispred registered alongside.
  - BHT[pc idx] saturating update: taken increments (max 3); not-taken decrements (min 0). Applied at the end of the EVAL cycle.
  - Next state: mispred -> REDIR with redir_pc=target latched; else -> IDLE.
- REDIR:
  - redir_valid=1; redir_pc stable until the handshake completes.
  - On redir_ready -> IDLE; redir_valid deasserts the next cycle.
- Latency:
  - Accept at cycle N; res_valid at N+1.
  - redir_valid from N+2 when mispredicted.
  - Earliest next accept: N+2 (correct prediction) or the cycle after redir_ready.
- flush:
  - Priority over everything.
  - In EVAL: suppress res_valid, the BHT update, and the redirect; go to IDLE.
  - In REDIR: drop redir_valid and go to IDLE; the BHT update has already occurred.
- BHT lookup: lkp_taken is combinational from the current array contents. A lookup in the same cycle as an update to the same entry returns the pre-update value.
- Asynchronous reset mid-EVAL or mid-REDIR: immediately return to reset values with no redirect.

Optional Feature:
- Macro BRANCH_RESOLVE_PERF_EN.
- Defined:
  - Adds outputs perf_branches[31:0] and perf_mispreds[31:0], both reset to 0.
  - perf_branches increments on every unflushed EVAL with a valid type.
  - perf_mispreds increments when, in addition, mispred=1.
  - Both wrap at 2^32.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then BEQ pc=0x80000000, reg1=reg2=5, imm=0x10, pred=0 -> res_valid at N+1 with taken=1, mispred=1; redir_pc=0x80000010 held until redir_ready; BHT idx0 goes 01->10.
- BLT reg1=-1 (0xFFFF_FFFF_FFFF_FFFF), reg2=1, pred=1 -> taken=1, mispred=0, no redir_valid; BLTU with the same operands -> taken=0, mispred=1, redir_pc=pc+4.
- Hold redir_ready=0 for 5 cycles -> redir_valid and redir_pc stable, in_ready=0; redir_ready=1 -> IDLE and in_ready=1 the next cycle.
- Four taken BNE at the same pc -> counter saturates at 3 and lkp_taken=1; five not-taken -> counter saturates at 0 and lkp_taken=0.
- flush asserted in EVAL of a mispredicted branch -> no res_valid, no redirect, BHT entry unchanged; a new request is accepted next cycle.
- pc=0xFFFF_FFFF_FFFF_FFFC, BGE not taken, pred=1 -> redir_pc=0x0 (wrap); with BRANCH_RESOLVE_PERF_EN defined, perf_branches=1 and perf_mispreds=1.
